// File: rtl/bram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_arbiter: three-port req/gnt arbiter in front of a single-port BRAM,
// in-order read return. Define BRAM_ARB_RR_EN for round-robin priority.
// Rev 1.0
// ---------------------------------------------------------------------------
module bram_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                hold,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                bram_en,
  output logic                bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_wdata,
  input  logic [DATA_W-1:0]   bram_rdata
);

  typedef struct packed {
    logic       vld;
    logic [1:0] port;
  } rd_tag_t;

  logic [2:0]        gnt_q, gnt_d;
  logic              bram_en_q, bram_en_d;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_wdata_q, bram_wdata_d;
  rd_tag_t           pipe_q [RD_LAT];
  rd_tag_t           pipe_d [RD_LAT];

  logic [2:0] elig;
  logic [1:0] win;
  logic       found;
  logic       grant;
  logic [1:0] gnt_port;

  // A port is masked during its own grant cycle so a held req is not re-issued.
  assign elig  = req & ~gnt_q;
  assign grant = found & ~hold;

`ifdef BRAM_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] sum;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    sum   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, ptr_q} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (!found && elig[sum[1:0]]) begin
        found = 1'b1;
        win   = sum[1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) ptr_q <= 2'd1;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    found = 1'b1;
    win   = 2'd0;
    if      (elig[1]) win = 2'd1;
    else if (elig[0]) win = 2'd0;
    else if (elig[2]) win = 2'd2;
    else              found = 1'b0;
  end
`endif

  assign gnt_port = gnt_q[2] ? 2'd2 : (gnt_q[1] ? 2'd1 : 2'd0);

  always_comb begin
    gnt_d        = 3'b000;
    bram_en_d    = 1'b0;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    if (grant) begin
      gnt_d        = 3'b001 << win;
      bram_en_d    = 1'b1;
      bram_we_d    = we[win];
      bram_addr_d  = addr[win*ADDR_W +: ADDR_W];
      bram_wdata_d = wdata[win*DATA_W +: DATA_W];
    end
    // Tag enters the pipe the cycle after bram_en, so its last stage lines up with C+RD_LAT.
    pipe_d[0].vld  = bram_en_q & ~bram_we_q;
    pipe_d[0].port = gnt_port;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      gnt_q        <= 3'b000;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i].vld  <= 1'b0;
        pipe_q[i].port <= 2'd0;
      end
    end else begin
      gnt_q        <= gnt_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign gnt        = gnt_q;
  assign bram_en    = bram_en_q;
  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;
  assign rvalid     = pipe_q[RD_LAT-1].vld ? (3'b001 << pipe_q[RD_LAT-1].port) : 3'b000;
  assign rdata      = bram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
// Testbench for bram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_bram_arbiter;
  localparam int AW = 19;
  localparam int DW = 32;
  parameter int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          hold = 1'b0;
  logic [2:0]    req = '0;
  logic [2:0]    we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]    gnt, rvalid;
  logic [DW-1:0] rdata, bram_rdata, bram_wdata;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .hold(hold), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  // BRAM primitive model with RD_LAT read latency
  logic [DW-1:0] mem [64];
  logic [DW-1:0] rpipe [RD_LAT];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (bram_en && bram_we) begin
      mem[bram_addr[5:0]] <= bram_wdata;
    end
    rpipe[0] <= (bram_en && !bram_we) ? mem[bram_addr[5:0]] : 32'h5A5A_0000;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bram_rdata = rpipe[RD_LAT-1];

  // Reference model state
  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] shadow [64];
  logic [2:0]    m_gnt = '0;
  logic          m_en = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_ptr = 1;
  logic [2:0]    m_rv;
  logic [DW-1:0] m_rdata;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] elig;
    int w;
    int order[3];
    ret_t r;
    if (!rstn) begin
      m_gnt = '0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_ptr = 1;
      rq.delete();
      for (int i = 0; i < 64; i++) shadow[i] = '0;
    end else begin
      elig = req & ~m_gnt;
      m_gnt = '0; m_en = 1'b0; m_we = 1'b0;
      w = -1;
`ifdef BRAM_ARB_RR_EN
      for (int k = 0; k < 3; k++) order[k] = (m_ptr + k) % 3;
`else
      order[0] = 1; order[1] = 0; order[2] = 2;
`endif
      if (!hold)
        for (int k = 0; k < 3; k++)
          if (w < 0 && elig[order[k]]) w = order[k];
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        m_en     = 1'b1;
        m_we     = we[w];
        m_addr   = addr[w*AW +: AW];
        m_wdata  = wdata[w*DW +: DW];
        if (m_we) shadow[m_addr[5:0]] = m_wdata;
        else begin
          r.due = cyc + RD_LAT; r.port = w; r.data = shadow[m_addr[5:0]];
          rq.push_back(r);
        end
        m_ptr = (w + 1) % 3;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    m_rv = '0;
    m_rdata = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      m_rv[rq[0].port] = 1'b1;
      m_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    chk("gnt", 64'(gnt), 64'(m_gnt));
    chk("bram_en", 64'(bram_en), 64'(m_en));
    chk("bram_we", 64'(bram_we), 64'(m_we));
    chk("bram_addr", 64'(bram_addr), 64'(m_addr));
    chk("bram_wdata", 64'(bram_wdata), 64'(m_wdata));
    chk("rvalid", 64'(rvalid), 64'(m_rv));
    if (m_rv != 0) chk("rdata", 64'(rdata), 64'(m_rdata));
  endtask

  task automatic do_reset();
    rstn = 1'b0; req = '0; we = '0; hold = 1'b0;
    cycle();
    cycle();
    rstn = 1'b1;
  endtask

  task automatic idle(int n);
    req = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [2:0] got [3];
    logic [2:0] exp_ord [3];
    logic [2:0] hist [6];
    int first;

    // Reset values
    do_reset();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_bram", 64'({bram_en, bram_we, bram_addr}), 64'(0));
    chk("rst_wdata", 64'(bram_wdata), 64'(0));

    // Port 1 write then read-back
    req = 3'b010; we = 3'b010;
    addr[AW +: AW] = AW'(16); wdata[DW +: DW] = 32'hDEADBEEF;
    cycle(); chk("wr_gnt", 64'(gnt), 64'(3'b010));
    we[1] = 1'b0;
    cycle(); chk("wr_gap", 64'(gnt), 64'(0));
    cycle(); chk("rd_gnt", 64'(gnt), 64'(3'b010));
    chk("rd_cmd", 64'({bram_en, bram_we}), 64'(2'b10));
    req = '0;
    for (int i = 1; i <= RD_LAT; i++) begin
      cycle();
      if (i < RD_LAT) chk("rd_early", 64'(rvalid), 64'(0));
    end
    chk("rd_rvalid", 64'(rvalid), 64'(3'b010));
    chk("rd_rdata", 64'(rdata), 64'(32'hDEADBEEF));
    idle(2);

    // Simultaneous requests
    do_reset();
    req = 3'b111; we = '0;
    addr = {AW'(3), AW'(2), AW'(1)};
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("simul_onehot", 64'($onehot(gnt)), 64'(1));
      got[k] = gnt;
      req = req & ~gnt;
    end
`ifdef BRAM_ARB_RR_EN
    exp_ord[0] = 3'b010; exp_ord[1] = 3'b100; exp_ord[2] = 3'b001;
`else
    exp_ord[0] = 3'b010; exp_ord[1] = 3'b001; exp_ord[2] = 3'b100;
`endif
    for (int k = 0; k < 3; k++) chk("simul_order", 64'(got[k]), 64'(exp_ord[k]));
    idle(RD_LAT + 2);

    // Port 2 against saturating ports 0/1
    do_reset();
    req = 3'b111; we = '0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (gnt[2] && first < 0) first = i;
    end
`ifdef BRAM_ARB_RR_EN
    chk("rr_bound", 64'(first >= 1 && first <= 6), 64'(1));
`else
    chk("starve", 64'(32'(first)), 64'(32'(-1)));
`endif
    idle(RD_LAT + 2);

    // hold freezes grants, not returns
    do_reset();
    req = 3'b001; we = '0; addr[0 +: AW] = AW'(4);
    cycle(); chk("hold_rd_gnt", 64'(gnt), 64'(3'b001));
    req = 3'b100; hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk("hold_gnt", 64'(gnt), 64'(0));
      if (i == RD_LAT) chk("hold_rvalid", 64'(rvalid), 64'(3'b001));
    end
    hold = 1'b0;
    cycle(); chk("hold_release", 64'(gnt), 64'(3'b100));
    idle(RD_LAT + 2);

    // Reset with a read outstanding
    do_reset();
    req = 3'b010; we = '0; addr[AW +: AW] = AW'(8);
    cycle(); chk("mid_gnt", 64'(gnt), 64'(3'b010));
    req = '0; rstn = 1'b0;
    cycle();
    chk("mid_rst_out", 64'({gnt, rvalid, bram_en, bram_we, bram_addr}), 64'(0));
    chk("mid_rst_wdata", 64'(bram_wdata), 64'(0));
    rstn = 1'b1;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      cycle();
      chk("mid_no_rvalid", 64'(rvalid), 64'(0));
    end

    // Back-to-back reads, port 0 then port 1
    do_reset();
    req = 3'b001; we = '0; addr[0 +: AW] = AW'(20);
    cycle(); chk("b2b_gnt0", 64'(gnt), 64'(3'b001));
    req = 3'b010; addr[AW +: AW] = AW'(21);
    cycle(); chk("b2b_gnt1", 64'(gnt), 64'(3'b010));
    hist[0] = rvalid;
    req = '0;
    for (int k = 1; k <= RD_LAT; k++) begin
      cycle();
      hist[k] = rvalid;
    end
    chk("b2b_rv0", 64'(hist[RD_LAT-1]), 64'(3'b001));
    chk("b2b_rv1", 64'(hist[RD_LAT]), 64'(3'b010));
    idle(2);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle();
      for (int i = 0; i < 3; i++) begin
        if (gnt[i] || (!req[i] && $urandom_range(0, 3) == 0)) begin
          req[i] = gnt[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          we[i] = 1'($urandom_range(0, 1));
          addr[i*AW +: AW] = AW'($urandom_range(0, 63));
          wdata[i*DW +: DW] = $urandom;
        end
      end
      hold = ($urandom_range(0, 9) == 0);
      rstn = ($urandom_range(0, 199) != 0);
    end
    rstn = 1'b1; hold = 1'b0;
    idle(RD_LAT + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
